// File: rtl/sram_req_adapter_pkg.sv
// sram_req_adapter_pkg: shared widths, request type and sizing helper for the SRAM request adapter.
package sram_req_adapter_pkg;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_RSP_DEPTH = 2;

    typedef struct packed {
        logic we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } req_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: circular read-data buffer with the head exposed combinationally.
module sram_rsp_fifo
    import sram_req_adapter_pkg::*;
#(
    parameter int DEPTH = DEF_RSP_DEPTH,
    parameter int WIDTH = DEF_DATA_WIDTH,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready front end for a 1-cycle-latency SRAM macro with buffered read responses.
module sram_req_adapter
    import sram_req_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_we,
    output logic                  sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);
    localparam int CW = cnt_width(RSP_DEPTH);
    localparam int OW = CW + 1;

    logic accept;
    logic pop;
    logic inflight_q;
    logic inflight;
    logic fifo_empty;
    logic fifo_full;
    logic [CW-1:0] count;
    logic [OW-1:0] occupancy;

    // Occupancy counts the read already at the macro so a full FIFO can never be overrun.
    assign accept = req_valid && req_ready;
    assign pop = rsp_valid && rsp_ready;
    assign occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);
    assign req_ready = !rst && (occupancy < OW'(RSP_DEPTH));
    assign rsp_valid = !rst && !fifo_empty;
    assign inflight = inflight_q && !rst;

    assign sram_we = accept && req_we;
    assign sram_wmask = 1'b1;
    assign sram_addr = req_addr;
    assign sram_din = req_wdata;

    always_ff @(posedge clk) begin
        inflight_q <= rst ? 1'b0 : accept && !req_we;
    end

    sram_rsp_fifo #(
        .DEPTH(RSP_DEPTH),
        .WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  (sram_dout),
        .dout (rsp_rdata),
        .count(count),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assert property (@(posedge clk) disable iff (rst) !(inflight && fifo_full));
endmodule

// File: doc/sram_req_adapter.md
SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, SRAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64, SRAM word width.
REQ-003 The block SHALL have parameter RSP_DEPTH, default 2, response FIFO entries (minimum 2).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1, request present.
REQ-007 The block SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-008 The block SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_WIDTH, word address.
REQ-010 The block SHALL have port req_wdata, input, DATA_WIDTH, write data.
REQ-011 The block SHALL have port rsp_valid, output, 1, read data present.
REQ-012 The block SHALL have port rsp_ready, input, 1, consumer takes rsp_rdata.
REQ-013 The block SHALL have port rsp_rdata, output, DATA_WIDTH, read data.
REQ-014 The block SHALL have ports sram_we (1), sram_wmask (1), sram_addr (ADDR_WIDTH) and sram_din (DATA_WIDTH), all outputs, that drive the SRAM22 macro.
REQ-015 The block SHALL have port sram_dout, input, DATA_WIDTH, macro read data, valid one cycle after a read edge.

Function
REQ-016 Accept SHALL mean req_valid and req_ready both high in the same cycle.
REQ-017 sram_addr SHALL equal req_addr and sram_din SHALL equal req_wdata, both combinational.
REQ-018 sram_wmask SHALL be constant 1.
REQ-019 sram_we SHALL equal accept AND req_we; sram_we SHALL be 0 on every cycle without a write accept.
REQ-020 An accepted read SHALL set a registered inflight flag for exactly the next cycle.
REQ-021 In the cycle where inflight is high, sram_dout SHALL be pushed into the response FIFO. sram_dout SHALL be ignored in all other cycles, including idle reads and the x-valued output after a write.
REQ-022 Writes SHALL produce no response.
REQ-023 rsp_valid SHALL be high whenever the FIFO is non-empty. rsp_rdata SHALL be the FIFO head, held stable while rsp_valid is high and rsp_ready is low.
REQ-024 A read accepted at cycle t SHALL give rsp_valid no earlier than cycle t+2, with an exact 2-cycle latency when the FIFO is empty.
REQ-025 Responses SHALL return in acceptance order.
REQ-026 req_ready SHALL equal (count + inflight - (rsp_valid AND rsp_ready)) < RSP_DEPTH, for reads and writes alike. It SHALL be forced low while rst is high.
REQ-027 The FIFO SHALL never overflow. A push while full SHALL be unreachable and flagged by an assertion.
REQ-028 Simultaneous push and pop SHALL leave count unchanged. Pointers SHALL wrap modulo RSP_DEPTH.
REQ-029 Sustained reads with rsp_ready held at 1 SHALL achieve 1 accept per cycle.
REQ-030 A read and a write to the same address in consecutive cycles SHALL be ordered by acceptance: a read after a write returns the new data.

Reset
REQ-031 While rst is high: req_ready = 0, rsp_valid = 0, inflight = 0, FIFO count = 0, pointers = 0, and sram_we = 0.
REQ-032 A read accepted in the cycle before rst rises SHALL be dropped with no response after reset.
REQ-033 FIFO data storage SHALL need no reset.
REQ-034 In the first cycle after rst falls: req_ready = 1 and rsp_valid = 0.

Structure
REQ-035 A shared package SHALL hold the default ADDR_WIDTH and DATA_WIDTH constants and a request struct type {we, addr, wdata}.
REQ-036 The response FIFO SHALL be a sub-module named sram_rsp_fifo (parameters DEPTH and WIDTH; ports push, pop, din, dout, count, empty, full).
REQ-037 The macro instance SHALL stay outside this block; integration is in the parent.

Verification
REQ-038 Write 0xDEADBEEF_0000_0005 to addr 5, then read addr 5 -> rsp_rdata = 0xDEADBEEF_0000_0005 exactly 2 cycles after the read accept.
REQ-039 Hold rsp_ready = 0 and issue reads of addr 0..3 -> exactly 2 accepted, then req_ready = 0. Raise rsp_ready -> data for addr 0 then addr 1, after which addr 2 and 3 are accepted.
REQ-040 Stream 64 back-to-back reads with rsp_ready = 1 -> 64 accepts in 64 cycles, with in-order data matching a preloaded pattern mem[i] = i*3.
REQ-041 Alternate write addr 9 = 0x1111 and read addr 9 every cycle -> each read returns the immediately preceding write, and no response is produced for any write.
REQ-042 Assert rst the cycle after a read accept -> rsp_valid stays 0 after reset, and req_ready = 1 in the first cycle after rst falls.
REQ-043 Randomly toggle rsp_ready for 1000 cycles -> no FIFO overflow assertion, and the response stream matches a scoreboard.
